// File: rtl/fetch_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_sequencer : MiniRISC multi-cycle fetch / PC sequencer (FETCH-WAIT-EXEC)
// Optional single-step PAUSE state enabled by defining FETCH_STEP_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int              PC_W     = 5,
  parameter int              INSTR_W  = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Run,
`ifdef FETCH_STEP_EN
  input  logic               i_Step,
`endif
  output logic [PC_W-1:0]    o_IMem_Addr,
  output logic               o_IMem_Rd,
  input  logic [INSTR_W-1:0] i_IMem_Data,
  output logic [2:0]         o_Op,
  output logic [1:0]         o_Rdst,
  output logic [2:0]         o_Rsrc_Imm,
  output logic               o_Exec,
  input  logic               i_PCSelect,
  input  logic [PC_W-1:0]    i_PCAddr,
  input  logic               i_Halt,
  output logic [PC_W-1:0]    o_PC,
  output logic               o_Halted
);

`ifdef FETCH_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4,
    S_PAUSE  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4
  } state_t;
`endif

  state_t             state, state_next;
  logic [PC_W-1:0]    pc, pc_next, pc_inc;
  logic [INSTR_W-1:0] ir;
  logic               ir_load;

  assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (ir_load) begin
        ir <= i_IMem_Data;
      end
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_load    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_Run) state_next = S_FETCH;
      end
      S_FETCH: state_next = S_WAIT;
      S_WAIT: begin
        ir_load    = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        // Halt wins over a jump and leaves PC on the HALT instruction.
        if (i_Halt) begin
          state_next = S_HALTED;
        end else begin
          pc_next = i_PCSelect ? i_PCAddr : pc_inc;
`ifdef FETCH_STEP_EN
          state_next = S_PAUSE;
`else
          state_next = S_FETCH;
`endif
        end
      end
      S_HALTED: begin
        if (i_Run) begin
          pc_next    = pc_inc;
          state_next = S_FETCH;
        end
      end
`ifdef FETCH_STEP_EN
      S_PAUSE: begin
        if (i_Step) state_next = S_FETCH;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  assign o_IMem_Addr = pc;
  assign o_PC        = pc;
  assign o_IMem_Rd   = (state == S_FETCH);
  assign o_Exec      = (state == S_EXEC);
  assign o_Halted    = (state == S_HALTED);
  assign o_Op        = ir[7:5];
  assign o_Rdst      = ir[4:3];
  assign o_Rsrc_Imm  = ir[2:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_sequencer : randomized self-checking bench with an instruction-level
// model of the PC sequencer and a behavioural synchronous ROM. Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, rd, exec, sel, halt, halted;
  logic [4:0] addr, paddr, pc;
  logic [7:0] data;
  logic [2:0] op, rsrc;
  logic [1:0] rdst;
`ifdef FETCH_STEP_EN
  logic       stp;
`endif

  int   total = 0;
  int   bad   = 0;
  int   m_pc;
  logic [7:0] m_ir;
  logic [7:0] rom [32];
  logic [7:0] rom_q;

  fetch_sequencer dut (
    .i_Clk(clk), .i_Rst(rst), .i_Run(run),
`ifdef FETCH_STEP_EN
    .i_Step(stp),
`endif
    .o_IMem_Addr(addr), .o_IMem_Rd(rd), .i_IMem_Data(data),
    .o_Op(op), .o_Rdst(rdst), .o_Rsrc_Imm(rsrc), .o_Exec(exec),
    .i_PCSelect(sel), .i_PCAddr(paddr), .i_Halt(halt),
    .o_PC(pc), .o_Halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd) rom_q <= rom[addr];
  assign data = rom_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    halt  = 1'($urandom);
    sel   = 1'($urandom);
    paddr = 5'($urandom);
  endtask

  // Caller guarantees the DUT is in FETCH; leaves it in FETCH or HALTED.
  task automatic do_instr(input logic h, input logic s, input logic [4:0] a);
    junk(); run = 1'($urandom);
    total++; if (rd !== 1'b1 || addr !== 5'(m_pc) || exec !== 1'b0) begin
      bad++; $display("FAIL fetch rd=%0b addr=%0d exec=%0b want rd=1 addr=%0d exec=0", rd, addr, exec, m_pc);
    end
    tick();
    junk(); run = 1'($urandom);
    total++; if (rd !== 1'b0 || exec !== 1'b0 || {op, rdst, rsrc} !== m_ir) begin
      bad++; $display("FAIL wait rd=%0b exec=%0b ir=%h want 0 0 ir=%h", rd, exec, {op, rdst, rsrc}, m_ir);
    end
    tick();
    m_ir = rom[m_pc];
    halt = h; sel = s; paddr = a; run = 1'($urandom);
    total++; if (exec !== 1'b1 || {op, rdst, rsrc} !== m_ir || pc !== 5'(m_pc)) begin
      bad++; $display("FAIL exec exec=%0b ir=%h pc=%0d want 1 ir=%h pc=%0d", exec, {op, rdst, rsrc}, pc, m_ir, m_pc);
    end
    tick();
    run = 1'b0; junk();
    if (h) begin
      total++; if (halted !== 1'b1 || pc !== 5'(m_pc) || rd !== 1'b0) begin
        bad++; $display("FAIL halt halted=%0b pc=%0d rd=%0b want 1 pc=%0d rd=0", halted, pc, rd, m_pc);
      end
    end else begin
      m_pc = s ? int'(a) : (m_pc + 1) % 32;
`ifdef FETCH_STEP_EN
      for (int i = 0; i < 3; i++) begin
        total++; if (rd !== 1'b0 || exec !== 1'b0 || pc !== 5'(m_pc) || {op, rdst, rsrc} !== m_ir) begin
          bad++; $display("FAIL pause rd=%0b exec=%0b pc=%0d want 0 0 pc=%0d", rd, exec, pc, m_pc);
        end
        tick();
      end
      stp = 1'b1;
      tick();
      stp = 1'b0;
`endif
      total++; if (rd !== 1'b1 || addr !== 5'(m_pc) || halted !== 1'b0) begin
        bad++; $display("FAIL next rd=%0b addr=%0d halted=%0b want rd=1 addr=%0d halted=0", rd, addr, halted, m_pc);
      end
    end
  endtask

  // From IDLE or HALTED: pulse i_Run for one edge.
  task automatic pulse_run(input logic from_halt);
    run = 1'b1;
    tick();
    run = 1'b0;
    if (from_halt) m_pc = (m_pc + 1) % 32;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; junk();
`ifdef FETCH_STEP_EN
    stp = 1'b0;
`endif
    tick(); tick();
    total++; if (pc !== 5'd0 || addr !== 5'd0 || rd !== 1'b0 || exec !== 1'b0 || halted !== 1'b0 ||
                 op !== 3'd0 || rdst !== 2'd0 || rsrc !== 3'd0) begin
      bad++; $display("FAIL reset pc=%0d addr=%0d rd=%0b exec=%0b halted=%0b ir=%h want all zero",
                      pc, addr, rd, exec, halted, {op, rdst, rsrc});
    end
    rst = 1'b0;
    m_pc = 0; m_ir = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (rd !== 1'b0 || exec !== 1'b0 || pc !== 5'd0) begin
        bad++; $display("FAIL idle rd=%0b exec=%0b pc=%0d want 0 0 0", rd, exec, pc);
      end
    end
  endtask

  task automatic test_run_first();
    pulse_run(1'b0);
    do_instr(1'b0, 1'b0, 5'd0);
    total++; if (pc !== 5'd1) begin
      bad++; $display("FAIL first_pc pc=%0d want 1", pc);
    end
  endtask

  task automatic test_jump();
    while (m_pc != 3) do_instr(1'b0, 1'b0, 5'd0);
    do_instr(1'b0, 1'b1, 5'd20);
    total++; if (addr !== 5'd20) begin
      bad++; $display("FAIL jump addr=%0d want 20", addr);
    end
  endtask

  task automatic test_halt_priority();
    do_instr(1'b0, 1'b1, 5'd7);
    do_instr(1'b1, 1'b1, 5'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (halted !== 1'b1 || pc !== 5'd7 || rd !== 1'b0) begin
        bad++; $display("FAIL halt_hold halted=%0b pc=%0d rd=%0b want 1 7 0", halted, pc, rd);
      end
    end
    pulse_run(1'b1);
    total++; if (addr !== 5'd8 || rd !== 1'b1) begin
      bad++; $display("FAIL resume addr=%0d rd=%0b want 8 1", addr, rd);
    end
  endtask

  task automatic test_wrap();
    do_instr(1'b0, 1'b1, 5'd31);
    do_instr(1'b0, 1'b0, 5'd0);
    total++; if (addr !== 5'd0) begin
      bad++; $display("FAIL wrap addr=%0d want 0", addr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic h;
      h = ($urandom_range(0, 7) == 0);
      do_instr(h, 1'($urandom), 5'($urandom));
      if (h) begin
        repeat ($urandom_range(0, 3)) tick();
        pulse_run(1'b1);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    tick(); tick();
    rst = 1'b1; halt = 1'b0; sel = 1'b1; paddr = 5'd9;
    total++; if (exec !== 1'b1) begin
      bad++; $display("FAIL pre_reset exec=%0b want 1", exec);
    end
    tick();
    total++; if (pc !== 5'd0 || exec !== 1'b0 || rd !== 1'b0 || halted !== 1'b0 || {op, rdst, rsrc} !== 8'h00) begin
      bad++; $display("FAIL mid_reset pc=%0d exec=%0b rd=%0b ir=%h want 0 0 0 00", pc, exec, rd, {op, rdst, rsrc});
    end
    rst = 1'b0; m_pc = 0; m_ir = 8'h00;
    tick();
    total++; if (rd !== 1'b0 || pc !== 5'd0) begin
      bad++; $display("FAIL post_reset_idle rd=%0b pc=%0d want 0 0", rd, pc);
    end
    pulse_run(1'b0);
    do_instr(1'b0, 1'b0, 5'd0);
    do_instr(1'b0, 1'b1, 5'd5);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h29;
    rom_q  = 8'h00;
    test_reset();
    test_run_first();
    test_jump();
    test_halt_priority();
    test_wrap();
    test_random();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
